instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, reset, which is synchronous and active-high.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h00000000, giving the PC loaded on reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  32  byte address of the fetch; always equals pc.
REQ-007 imem_ack  in  1  memory accepts the request and returns the word in the same cycle.
REQ-008 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-009 instr_valid  out  1  instr/op_code hold an instruction for the decode/datapath stage.
REQ-010 instr_ready  in  1  downstream consumes the issued instruction.
REQ-011 instr  out  32  registered instruction word.
REQ-012 op_code  out  6  instr[31:26], driven to the control unit.
REQ-013 pc_plus4  out  32  pc+4 of the issued instruction, used as the jal link value.
REQ-014 Jump  in  1  control-unit jump decision for the issued instruction.
REQ-015 Branch  in  1  control-unit branch decision for the issued instruction.
REQ-016 zero  in  1  ALU zero flag for the issued instruction.
REQ-017 illegal_op  out  1  sticky unsupported-opcode flag (see Configuration).

Function
REQ-018 FSM states SHALL be IDLE, FETCH, ISSUE and HALT.
REQ-019 IDLE SHALL go to FETCH unconditionally on the next cycle.
REQ-020 In FETCH, imem_req SHALL be 1; on imem_ack=1, imem_rdata SHALL be registered into instr and the state SHALL go to ISSUE.
REQ-021 Without imem_ack, FETCH SHALL hold imem_req and imem_addr stable.
REQ-022 In ISSUE, instr_valid SHALL be 1, imem_req SHALL be 0, and instr, op_code and pc_plus4 SHALL stay stable until instr_ready=1.
REQ-023 On the instr_valid & instr_ready cycle, pc SHALL load next_pc and the state SHALL return to FETCH.
REQ-024 next_pc priority: Jump=1 gives {pc_plus4[31:28], instr[25:0], 2'b00}; else Branch & zero gives pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-025 Jump, Branch and zero SHALL be sampled only in the accept cycle and ignored otherwise.
REQ-026 All PC arithmetic SHALL be modulo 2^32, so 32'hFFFFFFFC + 4 = 32'h00000000.
REQ-027 A negative branch offset SHALL be allowed; imm=16'hFFFF gives next_pc = pc.
REQ-028 Minimum throughput SHALL be one instruction per 2 cycles: an ack cycle, then an accept cycle.
REQ-029 HALT SHALL hold imem_req=0 and instr_valid=0 until reset.

Reset
REQ-030 While reset=1, the block SHALL set pc=RESET_PC, state=IDLE, and instr, pc_plus4, imem_req, instr_valid and illegal_op to 0.
REQ-031 Reset SHALL take priority over every event, including an imem_ack or accept in the same cycle; such data SHALL be discarded.
REQ-032 The first imem_req SHALL assert in the second cycle after reset deasserts, with imem_addr=RESET_PC.

Configuration
REQ-033 Macro IFU_ILLEGAL_OP_HALT_EN SHALL control unsupported-opcode handling.
REQ-034 The supported opcode set is 000000, 001000, 100011, 101011, 001100, 000100 and 000011.
REQ-035 With IFU_ILLEGAL_OP_HALT_EN defined, an acked word whose opcode is outside the supported set SHALL move FETCH to HALT instead of ISSUE.
REQ-036 In that case, illegal_op SHALL be set to 1, instr SHALL capture the word, and the word SHALL NOT be issued.
REQ-037 With IFU_ILLEGAL_OP_HALT_EN undefined, every opcode SHALL be issued normally, HALT SHALL be unreachable, and illegal_op SHALL be constant 0.

Verification
REQ-038 Reset, RESET_PC=0, imem_ack and instr_ready tied 1, R-type words -> imem_addr 0x0, 0x4, 0x8 on alternating cycles, with instr_valid high on the cycles between.
REQ-039 beq at pc 0x10 with imm 0x0003: zero=1 -> next imem_addr 0x20; zero=0 -> 0x14; imm 0xFFFF with zero=1 -> 0x10.
REQ-040 jal (op 000011) at pc 0x40 with target field 0x0000100 -> pc_plus4 = 0x44 while issued, next imem_addr 0x400.
REQ-041 instr_ready held 0 for 3 cycles in ISSUE -> instr, op_code and pc_plus4 unchanged, imem_req 0, then one accept and the fetch resumes.
REQ-042 reset asserted in FETCH coincident with imem_ack -> the word is dropped, instr_valid is 0, and the next request is at RESET_PC in the second post-reset cycle.
REQ-043 Opcode 000010 fetched -> with the macro: HALT, illegal_op=1 and no further imem_req; without the macro: issued normally with illegal_op=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Single-outstanding instruction fetch unit. Fetches from a
//            same-cycle-ack instruction memory, issues one word at a time
//            to decode, and computes the next PC (sequential, branch, jump).
//            Optional macro IFU_ILLEGAL_OP_HALT_EN halts on unsupported
//            opcodes and raises a sticky illegal_op flag.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  op_code,
    output logic [31:0] pc_plus4,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        zero,
    output logic        illegal_op
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] w_branch_off;
    logic [31:0] w_next_pc;
    logic        w_op_legal;

`ifdef IFU_ILLEGAL_OP_HALT_EN
    logic        illegal_op_q, illegal_op_d;

    // Classify the incoming memory word against the supported opcode set
    always_comb begin
        case (imem_rdata[31:26])
            6'b000000, 6'b001000, 6'b100011, 6'b101011,
            6'b001100, 6'b000100, 6'b000011: w_op_legal = 1'b1;
            default:                         w_op_legal = 1'b0;
        endcase
    end

    assign illegal_op = illegal_op_q;
`else
    // Every opcode is issued; the flag never rises
    assign w_op_legal = 1'b1;
    assign illegal_op = 1'b0;
`endif

    // Next PC for the issued instruction: jump beats branch beats sequential
    always_comb begin
        w_branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        if (Jump)
            w_next_pc = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
        else if (Branch && zero)
            w_next_pc = pc_plus4_q + w_branch_off;
        else
            w_next_pc = pc_plus4_q;
    end

    // FSM next-state and datapath register updates
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
`ifdef IFU_ILLEGAL_OP_HALT_EN
        illegal_op_d = illegal_op_q;
`endif
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    pc_plus4_d = pc_q + 32'd4;
                    if (w_op_legal) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = HALT;
`ifdef IFU_ILLEGAL_OP_HALT_EN
                        illegal_op_d = 1'b1;
`endif
                    end
                end
            end
            ISSUE: begin
                // Control inputs only matter on the accept cycle
                if (instr_ready) begin
                    pc_d    = w_next_pc;
                    state_d = FETCH;
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any same-cycle ack or accept
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            pc_plus4_q <= 32'h0;
`ifdef IFU_ILLEGAL_OP_HALT_EN
            illegal_op_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
`ifdef IFU_ILLEGAL_OP_HALT_EN
            illegal_op_q <= illegal_op_d;
`endif
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == ISSUE);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign op_code     = instr_q[31:26];
    assign pc_plus4    = pc_plus4_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed self-checking bench for instr_fetch_unit
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  op_code;
    logic [31:0] pc_plus4;
    logic        Jump;
    logic        Branch;
    logic        zero;
    logic        illegal_op;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .op_code     (op_code),
        .pc_plus4    (pc_plus4),
        .Jump        (Jump),
        .Branch      (Branch),
        .zero        (zero),
        .illegal_op  (illegal_op)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled 1 ns after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one word with ack in FETCH; land in ISSUE (or HALT)
    task automatic deliver(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
    endtask

    // Accept the issued word with the given control decisions
    task automatic accept(input logic j, input logic b, input logic z);
        instr_ready = 1'b1;
        Jump = j; Branch = b; zero = z;
        step();
        instr_ready = 1'b0;
        Jump = 1'b0; Branch = 1'b0; zero = 1'b0;
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
        Jump = 1'b0; Branch = 1'b0; zero = 1'b0;
        step(); step();

        // Reset state
        chk("rst_req",   imem_req,    32'd0);
        chk("rst_valid", instr_valid, 32'd0);
        chk("rst_instr", instr,       32'h0);
        chk("rst_pc4",   pc_plus4,    32'h0);
        chk("rst_addr",  imem_addr,   32'h0);
        chk("rst_ill",   illegal_op,  32'd0);

        // First post-reset cycle is IDLE, request follows in the second
        reset = 1'b0;
        chk("idle_req", imem_req, 32'd0);
        step();
        chk("first_req",  imem_req,  32'd1);
        chk("first_addr", imem_addr, 32'h0);

        // Ack and ready tied high: streaming R-type words
        imem_ack = 1'b1; instr_ready = 1'b1; imem_rdata = 32'h0022_1820;
        step();
        chk("s0_valid", instr_valid, 32'd1);
        chk("s0_req",   imem_req,    32'd0);
        chk("s0_instr", instr,       32'h0022_1820);
        chk("s0_pc4",   pc_plus4,    32'h4);
        step();
        chk("s1_addr", imem_addr, 32'h4);
        chk("s1_req",  imem_req,  32'd1);
        step();
        chk("s1_valid", instr_valid, 32'd1);
        chk("s1_pc4",   pc_plus4,    32'h8);
        step();
        chk("s2_addr", imem_addr, 32'h8);

        // No ack: request and address hold; stray Jump ignored
        imem_ack = 1'b0; instr_ready = 1'b0; Jump = 1'b1;
        step(); step();
        Jump = 1'b0;
        chk("hold_req",  imem_req,  32'd1);
        chk("hold_addr", imem_addr, 32'h8);

        // jal at 0x8 to 0x10
        deliver(32'h0C00_0004);
        chk("j1_op",  op_code,  32'h3);
        chk("j1_pc4", pc_plus4, 32'hC);
        accept(1'b1, 1'b0, 1'b0);
        chk("j1_addr", imem_addr, 32'h10);

        // beq imm 3, zero=1 -> 0x20
        deliver(32'h1022_0003);
        chk("beq_t_pc4", pc_plus4, 32'h14);
        accept(1'b0, 1'b1, 1'b1);
        chk("beq_taken", imem_addr, 32'h20);

        // back to 0x10; beq zero=0 -> 0x14
        deliver(32'h0C00_0004);
        accept(1'b1, 1'b0, 1'b0);
        chk("j2_addr", imem_addr, 32'h10);
        deliver(32'h1022_0003);
        accept(1'b0, 1'b1, 1'b0);
        chk("beq_not", imem_addr, 32'h14);

        // back to 0x10; beq imm FFFF zero=1 -> 0x10
        deliver(32'h0C00_0004);
        accept(1'b1, 1'b0, 1'b0);
        deliver(32'h1022_FFFF);
        accept(1'b0, 1'b1, 1'b1);
        chk("beq_neg", imem_addr, 32'h10);

        // jal to 0x40, then jal at 0x40 with target 0x100 under a 3-cycle stall
        deliver(32'h0C00_0010);
        accept(1'b1, 1'b0, 1'b0);
        chk("j3_addr", imem_addr, 32'h40);
        deliver(32'h0C00_0100);
        Jump = 1'b1; Branch = 1'b1; zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", instr_valid, 32'd1);
            chk("stall_req",   imem_req,    32'd0);
            chk("stall_instr", instr,       32'h0C00_0100);
            chk("stall_op",    op_code,     32'h3);
            chk("stall_pc4",   pc_plus4,    32'h44);
            step();
        end
        chk("stall_addr", imem_addr, 32'h40);
        accept(1'b1, 1'b0, 1'b0);
        chk("jal_addr", imem_addr, 32'h400);
        chk("jal_req",  imem_req,  32'd1);

        // Reset coincident with an ack in FETCH
        reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h0022_1820;
        step();
        reset = 1'b0; imem_ack = 1'b0;
        chk("rack_valid", instr_valid, 32'd0);
        chk("rack_instr", instr,       32'h0);
        chk("rack_req",   imem_req,    32'd0);
        step();
        chk("rack_req2",  imem_req,  32'd1);
        chk("rack_addr2", imem_addr, 32'h0);

        // beq imm FFFE at pc 0 -> 0xFFFFFFFC, then wrap to 0
        deliver(32'h1000_FFFE);
        accept(1'b0, 1'b1, 1'b1);
        chk("wrap_hi", imem_addr, 32'hFFFF_FFFC);
        deliver(32'h0022_1820);
        chk("wrap_pc4", pc_plus4, 32'h0);
        accept(1'b0, 1'b0, 1'b0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Unsupported opcode 000010
        deliver(32'h0800_0000);
`ifdef IFU_ILLEGAL_OP_HALT_EN
        chk("ill_flag",  illegal_op,  32'd1);
        chk("ill_valid", instr_valid, 32'd0);
        chk("ill_instr", instr,       32'h0800_0000);
        instr_ready = 1'b1;
        step(); step();
        instr_ready = 1'b0;
        chk("halt_req",   imem_req,    32'd0);
        chk("halt_valid", instr_valid, 32'd0);
        chk("halt_flag",  illegal_op,  32'd1);
`else
        chk("ill_flag",  illegal_op,  32'd0);
        chk("ill_valid", instr_valid, 32'd1);
        chk("ill_op",    op_code,     32'h2);
        accept(1'b0, 1'b0, 1'b0);
        chk("ill_next", imem_addr, 32'h4);
        chk("ill_req",  imem_req,  32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
